// File: rtl/pcs_pkg.sv
// pcs_pkg: shared types and widths for the PCS transmit path
package pcs_pkg;
  localparam int CODE_W = 10;
  localparam int PMA_WORD_W = 20;
  typedef enum logic [1:0] {HUNT, LOW, EVEN} gearbox_state_t;
endpackage

// File: rtl/pcs_sync_fifo.sv
// pcs_sync_fifo: first-word-fall-through synchronous FIFO with occupancy level
module pcs_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic                       push_ok,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] level_q, level_d;
  logic pop_ok;
  assign empty = level_q == '0;
  assign full = level_q == (AW+1)'(DEPTH);
  assign level = level_q;
  assign rdata = mem_q[rptr_q];
  assign pop_ok = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok = push & (~full | pop_ok);
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wptr_q] = wdata;
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_ok ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/pma_tx_gearbox.sv
// pma_tx_gearbox: pairs even/odd 10-bit code groups into 20-bit PMA words via a FWFT FIFO
module pma_tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CODE_W-1:0]         tx_code_group,
  input  logic                      tx_code_valid,
  input  logic                      tx_even,
  output logic [PMA_WORD_W-1:0]     pma_tx_data,
  output logic                      pma_tx_valid,
  input  logic                      pma_tx_ready,
  output logic                      aligned,
  output logic                      align_err,
  output logic                      overflow,
  output logic [7:0]                underflow_cnt,
  output logic [$clog2(DEPTH):0]    fill_level
);
  gearbox_state_t state_q, state_d;
  logic [CODE_W-1:0] low_q, low_d;
  logic align_err_q, align_err_d, overflow_q, overflow_d;
  logic [7:0] ucnt_q, ucnt_d;
  logic push, push_ok, empty, full;
  assign aligned = state_q != HUNT;
  assign pma_tx_valid = ~empty;
  assign align_err = align_err_q;
  assign overflow = overflow_q;
  assign underflow_cnt = ucnt_q;
  always_comb begin
    state_d = state_q;
    low_d = low_q;
    align_err_d = 1'b0;
    push = 1'b0;
    if (tx_code_valid) begin
      case (state_q)
        HUNT: begin
          low_d = tx_even ? tx_code_group : low_q;
          state_d = tx_even ? LOW : HUNT;
        end
        LOW: begin
          low_d = tx_even ? tx_code_group : low_q;
          align_err_d = tx_even;
          push = ~tx_even;
          state_d = tx_even ? LOW : EVEN;
        end
        EVEN: begin
          low_d = tx_even ? tx_code_group : low_q;
          align_err_d = ~tx_even;
          state_d = tx_even ? LOW : HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
    overflow_d = overflow_q | (push & ~push_ok);
    ucnt_d = (aligned && pma_tx_ready && empty && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      low_q <= '0;
      align_err_q <= 1'b0;
      overflow_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      state_q <= state_d;
      low_q <= low_d;
      align_err_q <= align_err_d;
      overflow_q <= overflow_d;
      ucnt_q <= ucnt_d;
    end
  end
  pcs_sync_fifo #(.WIDTH(PMA_WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata({tx_code_group, low_q}),
    .pop(pma_tx_ready),
    .push_ok(push_ok),
    .rdata(pma_tx_data),
    .empty(empty),
    .full(full),
    .level(fill_level)
  );
endmodule
